// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and constants for the pipeline hazard unit.
//
// Contents:
//   sb_rec_t     scoreboard record {valid, wr, rd, is_load}; rd is sized for
//                the widest supported register number and zero-extended
//   SB_INVALID   the empty record shifted in for bubbles and reset
//   FWD_REGFILE  forward-select code meaning "read the register file"
//   STG_*        stage indices of EX, MEM and WB in the scoreboard
package hazard_pkg;

  localparam int REG_W_MAX = 8;

  localparam int FWD_REGFILE = 0;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [REG_W_MAX-1:0] rd;
    logic                 is_load;
  } sb_rec_t;

  localparam sb_rec_t SB_INVALID = '0;

endpackage

// File: rtl/hazard_match.sv
// hazard_match -- youngest-match priority encoder for one source operand.
//
// Ports:
//   src_use_i    source is actually read by the decode instruction
//   src_i        source register number
//   sb_i         scoreboard records, index 0 = youngest (EX)
//   hit_o        some stage will write this source
//   hit_stage_o  index of the youngest matching stage
//   hit_load_o   the youngest matching record is a load
//   fwd_o        forward select: FWD_REGFILE on no hit, else stage index + 1
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int REG_W  = 5,
  parameter int FW     = 2
) (
  input  logic                  src_use_i,
  input  logic [REG_W-1:0]      src_i,
  input  sb_rec_t [NSTAGE-1:0]  sb_i,
  output logic                  hit_o,
  output logic [FW-1:0]         hit_stage_o,
  output logic                  hit_load_o,
  output logic [FW-1:0]         fwd_o
);

  logic [NSTAGE-1:0] match;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_match
      assign match[gi] = src_use_i && (src_i != '0) &&
                         sb_i[gi].valid && sb_i[gi].wr &&
                         (sb_i[gi].rd == REG_W_MAX'(src_i));
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    hit_o       = 1'b0;
    hit_stage_o = '0;
    hit_load_o  = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o       = 1'b1;
        hit_stage_o = FW'(i);
        hit_load_o  = sb_i[i].is_load;
      end
    end
  end

  assign fwd_o = hit_o ? (hit_stage_o + FW'(1)) : FW'(FWD_REGFILE);

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit -- scoreboard-based data-hazard detection and forwarding.
//
// Tracks NSTAGE in-flight records after decode (0=EX, 1=MEM, 2=WB, ...),
// picks forwarding sources for the decode operands and raises a stall when
// a value is not yet available.
//
// Build option: HAZARD_FWD_EN
//   defined   -> forwarding enabled; only a load younger than LOAD_STAGE stalls
//   undefined -> no forwarding; any pending write to a source interlocks
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   id_valid                    decode slot holds a real instruction
//   id_rs/id_rt, *_use          source registers and whether they are read
//   id_rf_nwe, id_rd, id_is_ram decode writes id_rd; it is a load
//   exe_stall                   multi-cycle EX unit is busy
//   flush                       kill the decode instruction
//   hazard_stall                hold PC and IF/ID
//   ex_bubble                   bubble inserted into EX this edge
//   rs_fwd, rt_fwd              0 = regfile, k = stage k-1
//   stage_valid                 per-stage scoreboard valid bits
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int NSTAGE     = 3,
  parameter  int LOAD_STAGE = 1,
  parameter  int REG_W      = 5,
  localparam int FW         = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_rf_nwe,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_is_ram,
  input  logic              exe_stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_bubble,
  output logic [FW-1:0]     rs_fwd,
  output logic [FW-1:0]     rt_fwd,
  output logic [NSTAGE-1:0] stage_valid
);

  sb_rec_t [NSTAGE-1:0] sb_q;
  sb_rec_t [NSTAGE-1:0] sb_d;
  sb_rec_t              dec_rec;

  logic          rs_hit, rt_hit;
  logic          rs_ld, rt_ld;
  logic [FW-1:0] rs_stg, rt_stg;
  logic [FW-1:0] rs_fwd_m, rt_fwd_m;
  logic          dep_stall;
  logic          accept;

  hazard_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .FW(FW)) u_rs_match (
    .src_use_i   (id_rs_use),
    .src_i       (id_rs),
    .sb_i        (sb_q),
    .hit_o       (rs_hit),
    .hit_stage_o (rs_stg),
    .hit_load_o  (rs_ld),
    .fwd_o       (rs_fwd_m)
  );

  hazard_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .FW(FW)) u_rt_match (
    .src_use_i   (id_rt_use),
    .src_i       (id_rt),
    .sb_i        (sb_q),
    .hit_o       (rt_hit),
    .hit_stage_o (rt_stg),
    .hit_load_o  (rt_ld),
    .fwd_o       (rt_fwd_m)
  );

`ifdef HAZARD_FWD_EN
  // Load data only exists from LOAD_STAGE onward; a younger load must wait.
  localparam logic [FW-1:0] LOAD_IDX = FW'(LOAD_STAGE);

  assign dep_stall = (rs_hit && rs_ld && (rs_stg < LOAD_IDX)) ||
                     (rt_hit && rt_ld && (rt_stg < LOAD_IDX));
  assign rs_fwd    = rs_fwd_m;
  assign rt_fwd    = rt_fwd_m;
`else
  // Without bypass paths the consumer waits until the producer retires.
  logic unused_fwd;
  assign unused_fwd = ^{rs_ld, rt_ld, rs_stg, rt_stg, rs_fwd_m, rt_fwd_m};

  assign dep_stall = rs_hit | rt_hit;
  assign rs_fwd    = FW'(FWD_REGFILE);
  assign rt_fwd    = FW'(FWD_REGFILE);
`endif

  // A flushed instruction is dropped rather than stalled.
  assign hazard_stall = exe_stall | (id_valid & ~flush & dep_stall);
  assign ex_bubble    = ~exe_stall & id_valid & (flush | dep_stall);
  assign accept       = id_valid & ~flush & ~dep_stall;

  always_comb begin
    dec_rec         = SB_INVALID;
    dec_rec.valid   = 1'b1;
    dec_rec.wr      = id_rf_nwe;
    dec_rec.rd      = REG_W_MAX'(id_rd);
    dec_rec.is_load = id_is_ram;
  end

  // While EX is busy its record stays put and MEM receives a bubble; the
  // stages past MEM keep draining.
  assign sb_d[0] = exe_stall ? sb_q[0] : (accept ? dec_rec : SB_INVALID);

  genvar gi;
  generate
    for (gi = 1; gi < NSTAGE; gi++) begin : g_shift
      if (gi == 1) begin : g_mem
        assign sb_d[gi] = exe_stall ? SB_INVALID : sb_q[gi-1];
      end else begin : g_late
        assign sb_d[gi] = sb_q[gi-1];
      end
    end
    for (gi = 0; gi < NSTAGE; gi++) begin : g_valid
      assign stage_valid[gi] = sb_q[gi].valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
`timescale 1ns/1ps
module tb_pipe_hazard_unit;

  localparam int NSTAGE     = 3;
  localparam int LOAD_STAGE = 1;
  localparam int REG_W      = 5;
  localparam int FW         = $clog2(NSTAGE + 1);

`ifdef HAZARD_FWD_EN
  localparam int EXP_ALU_STALLS  = 0;
  localparam int EXP_LOAD_STALLS = 1;
  localparam int EXP_LOAD_RTF    = 2;
  localparam int EXP_R8_RSF      = 1;
  localparam int EXP_R10_RSF     = 1;
  localparam int EXP_R10_STALL   = 0;
  localparam int EXP_R11_RSF     = 1;
`else
  localparam int EXP_ALU_STALLS  = 3;
  localparam int EXP_LOAD_STALLS = 3;
  localparam int EXP_LOAD_RTF    = 0;
  localparam int EXP_R8_RSF      = 0;
  localparam int EXP_R10_RSF     = 0;
  localparam int EXP_R10_STALL   = 1;
  localparam int EXP_R11_RSF     = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_W-1:0]  id_rs = '0;
  logic [REG_W-1:0]  id_rt = '0;
  logic              id_rs_use = 1'b0;
  logic              id_rt_use = 1'b0;
  logic              id_rf_nwe = 1'b0;
  logic [REG_W-1:0]  id_rd = '0;
  logic              id_is_ram = 1'b0;
  logic              exe_stall = 1'b0;
  logic              flush = 1'b0;
  logic              hazard_stall;
  logic              ex_bubble;
  logic [FW-1:0]     rs_fwd;
  logic [FW-1:0]     rt_fwd;
  logic [NSTAGE-1:0] stage_valid;

  int tests = 0;
  int fails = 0;

  pipe_hazard_unit #(.NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .REG_W(REG_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_use    (id_rs_use),
    .id_rt_use    (id_rt_use),
    .id_rf_nwe    (id_rf_nwe),
    .id_rd        (id_rd),
    .id_is_ram    (id_is_ram),
    .exe_stall    (exe_stall),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .ex_bubble    (ex_bubble),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .stage_valid  (stage_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight instructions, each tagged with the stage it currently occupies.
  typedef struct {
    int stg;
    bit wr;
    int rd;
    bit ld;
  } ent_t;
  ent_t mq[$];

  function automatic void mfind(input bit u, input int src, output int stg, output bit ld);
    stg = -1;
    ld  = 1'b0;
    if (u && src != 0) begin
      foreach (mq[k]) begin
        if (mq[k].wr && mq[k].rd == src && (stg < 0 || mq[k].stg < stg)) begin
          stg = mq[k].stg;
          ld  = mq[k].ld;
        end
      end
    end
  endfunction

  function automatic void model_eval(output int e_rsf, output int e_rtf, output bit e_dep);
    int sa, sb;
    bit la, lb;
    mfind(id_rs_use, int'(id_rs), sa, la);
    mfind(id_rt_use, int'(id_rt), sb, lb);
`ifdef HAZARD_FWD_EN
    e_rsf = sa + 1;
    e_rtf = sb + 1;
    e_dep = (sa >= 0 && la && sa < LOAD_STAGE) || (sb >= 0 && lb && sb < LOAD_STAGE);
`else
    e_rsf = 0;
    e_rtf = 0;
    e_dep = (sa >= 0) || (sb >= 0);
`endif
  endfunction

  function automatic void model_step();
    int a, b;
    bit dep;
    ent_t nq[$];
    ent_t e;
    model_eval(a, b, dep);
    foreach (mq[k]) begin
      e = mq[k];
      if (!(exe_stall && e.stg == 0)) e.stg++;
      if (e.stg < NSTAGE) nq.push_back(e);
    end
    if (!exe_stall && id_valid && !flush && !dep)
      nq.push_back('{0, id_rf_nwe, int'(id_rd), id_is_ram});
    mq = nq;
  endfunction

  // Compare process: check every cycle at the falling edge, advance at rising.
  initial begin
    int a, b;
    bit dep;
    bit e_st, e_bu;
    logic [NSTAGE-1:0] e_sv;
    forever begin
      @(negedge clk);
      if (!resetn) mq.delete();
      model_eval(a, b, dep);
      e_st = exe_stall | (id_valid & ~flush & dep);
      e_bu = ~exe_stall & id_valid & (flush | dep);
      e_sv = '0;
      foreach (mq[k]) e_sv[mq[k].stg] = 1'b1;
      chk("model hazard_stall", hazard_stall, e_st);
      chk("model ex_bubble", ex_bubble, e_bu);
      chk("model rs_fwd", rs_fwd, a);
      chk("model rt_fwd", rt_fwd, b);
      chk("model stage_valid", stage_valid, e_sv);
      @(posedge clk);
      if (!resetn) mq.delete();
      else model_step();
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit v;
    int rs;
    bit rsu;
    int rt;
    bit rtu;
    bit wr;
    int rd;
    bit ld;
  } instr_t;

  localparam instr_t IDLE = '{0, 0, 0, 0, 0, 0, 0, 0};

  task automatic drive(input instr_t i, input bit fl = 1'b0, input bit xs = 1'b0);
    @(posedge clk);
    #1;
    id_valid  = i.v;
    id_rs     = REG_W'(i.rs);
    id_rs_use = i.rsu;
    id_rt     = REG_W'(i.rt);
    id_rt_use = i.rtu;
    id_rf_nwe = i.wr;
    id_rd     = REG_W'(i.rd);
    id_is_ram = i.ld;
    flush     = fl;
    exe_stall = xs;
    #1;
  endtask

  task automatic drain();
    repeat (4) drive(IDLE);
  endtask

  // Holds the same decode instruction while the unit stalls (bounded).
  task automatic count_stalls(input instr_t i, output int n);
    n = 0;
    while (hazard_stall && n < 10) begin
      n++;
      drive(i);
    end
  endtask

  initial begin
    int n;
    instr_t r;
    bit fl, xs;

    // Reset state.
    #2;
    chk("reset hazard_stall", hazard_stall, 0);
    chk("reset ex_bubble", ex_bubble, 0);
    chk("reset rs_fwd", rs_fwd, 0);
    chk("reset rt_fwd", rt_fwd, 0);
    chk("reset stage_valid", stage_valid, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // ALU r8 then read r8 as rs.
    drive('{1, 0, 0, 0, 0, 1, 8, 0});
    drive('{1, 8, 1, 0, 0, 1, 3, 0});
    chk("alu_fwd rs_fwd", rs_fwd, EXP_R8_RSF);
    count_stalls('{1, 8, 1, 0, 0, 1, 3, 0}, n);
    chk("alu_fwd stall cycles", n, EXP_ALU_STALLS);
    $display("[TB] alu r8 -> rs: %0d stall cycles", n);
    drain();

    // Load r9 then immediate use as rt.
    drive('{1, 0, 0, 0, 0, 1, 9, 1});
    drive('{1, 0, 0, 9, 1, 1, 2, 0});
    chk("load_use stall", hazard_stall, 1);
    chk("load_use bubble", ex_bubble, 1);
    count_stalls('{1, 0, 0, 9, 1, 1, 2, 0}, n);
    chk("load_use stall cycles", n, EXP_LOAD_STALLS);
    chk("load_use rt_fwd", rt_fwd, EXP_LOAD_RTF);
    $display("[TB] load r9 -> rt: %0d stall cycles, rt_fwd=%0d", n, rt_fwd);
    drain();

    // r10 in stages 0 and 2, r0 written in stage 1.
    drive('{1, 0, 0, 0, 0, 1, 10, 0});
    drive('{1, 0, 0, 0, 0, 1, 0, 0});
    drive('{1, 0, 0, 0, 0, 1, 10, 0});
    drive('{1, 10, 1, 0, 1, 0, 0, 0});
    chk("youngest rs_fwd", rs_fwd, EXP_R10_RSF);
    chk("r0 rt_fwd", rt_fwd, 0);
    chk("youngest stall", hazard_stall, EXP_R10_STALL);
    $display("[TB] r10 youngest: rs_fwd=%0d rt_fwd=%0d", rs_fwd, rt_fwd);
    drain();

    // exe_stall for 4 cycles with ALU r11 in EX.
    drive('{1, 0, 0, 0, 0, 1, 12, 0});
    drive('{1, 0, 0, 0, 0, 1, 11, 0});
    drive('{1, 11, 1, 0, 0, 0, 0, 0}, 1'b0, 1'b1);
    chk("exe_stall c0 stage_valid", stage_valid, 3'b011);
    chk("exe_stall c0 stall", hazard_stall, 1);
    chk("exe_stall c0 bubble", ex_bubble, 0);
    drive('{1, 11, 1, 0, 0, 0, 0, 0}, 1'b0, 1'b1);
    chk("exe_stall c1 stage_valid", stage_valid, 3'b101);
    chk("exe_stall c1 stall", hazard_stall, 1);
    chk("exe_stall c1 bubble", ex_bubble, 0);
    drive('{1, 11, 1, 0, 0, 0, 0, 0}, 1'b0, 1'b1);
    chk("exe_stall c2 stage_valid", stage_valid, 3'b001);
    chk("exe_stall c2 stall", hazard_stall, 1);
    drive('{1, 11, 1, 0, 0, 0, 0, 0}, 1'b0, 1'b1);
    chk("exe_stall c3 stage_valid", stage_valid, 3'b001);
    chk("exe_stall c3 stall", hazard_stall, 1);
    chk("exe_stall c3 bubble", ex_bubble, 0);
    chk("exe_stall held rs_fwd", rs_fwd, EXP_R11_RSF);
    $display("[TB] exe_stall x4: stage_valid=%b", stage_valid);
    drain();

    // Load-use with flush: flush wins.
    drive('{1, 0, 0, 0, 0, 1, 9, 1});
    drive('{1, 0, 0, 9, 1, 1, 4, 0}, 1'b1);
    chk("flush stall", hazard_stall, 0);
    chk("flush bubble", ex_bubble, 1);
    drive(IDLE);
    chk("flush nothing entered", stage_valid, 3'b010);
    $display("[TB] load-use + flush: stage_valid=%b", stage_valid);
    drain();

    // Full pipe, then asynchronous reset.
    drive('{1, 0, 0, 0, 0, 1, 5, 0});
    drive('{1, 0, 0, 0, 0, 1, 6, 1});
    drive('{1, 0, 0, 0, 0, 1, 7, 0});
    drive(IDLE);
    chk("full stage_valid", stage_valid, 3'b111);
    #1 resetn = 1'b0;
    #1;
    chk("async reset stage_valid", stage_valid, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    drive('{1, 5, 1, 6, 1, 0, 0, 0});
    chk("post reset rs_fwd", rs_fwd, 0);
    chk("post reset rt_fwd", rt_fwd, 0);
    chk("post reset stall", hazard_stall, 0);
    $display("[TB] reset mid-operation: stage_valid cleared");
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r.v   = ($urandom_range(0, 3) != 0);
      r.rs  = int'($urandom_range(0, 3));
      r.rsu = ($urandom_range(0, 3) != 0);
      r.rt  = int'($urandom_range(0, 3));
      r.rtu = ($urandom_range(0, 1) != 0);
      r.wr  = ($urandom_range(0, 3) != 0);
      r.rd  = int'($urandom_range(0, 3));
      r.ld  = ($urandom_range(0, 2) == 0);
      fl    = ($urandom_range(0, 7) == 0);
      xs    = ($urandom_range(0, 5) == 0);
      drive(r, fl, xs);
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
      end
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, meaning in-flight stages after decode (0=EX, 1=MEM, 2=WB); legal range 2..8.
REQ-002 SHALL have parameter LOAD_STAGE, default 1, meaning the first stage index whose load data is forwardable; legal range 1..NSTAGE-1.
REQ-003 SHALL have parameter REG_W, default 5, meaning the register-number width.
REQ-004 SHALL have port clk  in  1  meaning the single clock, rising edge.
REQ-005 SHALL have port resetn  in  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have port id_valid  in  1  meaning the decode slot holds a real instruction.
REQ-007 SHALL have ports id_rs and id_rt  in  REG_W each  meaning the source register numbers.
REQ-008 SHALL have ports id_rs_use and id_rt_use  in  1 each  meaning the corresponding source is actually read.
REQ-009 SHALL have ports id_rf_nwe  in  1, id_rd  in  REG_W and id_is_ram  in  1  meaning the decode instruction writes id_rd, and is a load.
REQ-010 SHALL have port exe_stall  in  1  meaning the multi-cycle EX unit is busy.
REQ-011 SHALL have port flush  in  1  meaning kill the decode instruction (branch redirect).
REQ-012 SHALL have ports hazard_stall  out  1 (hold PC and IF/ID) and ex_bubble  out  1 (bubble inserted into EX this edge).
REQ-013 SHALL have ports rs_fwd and rt_fwd  out  FW=$clog2(NSTAGE+1) each  meaning 0 selects the regfile and k selects stage k-1.
REQ-014 SHALL have port stage_valid  out  NSTAGE  meaning the per-stage scoreboard valid bits.

Function
REQ-015 SHALL keep a scoreboard of NSTAGE registered records {valid, wr, rd, is_load}.
REQ-016 A source SHALL match stage i iff: use=1, src!=0, valid_i, wr_i, and rd_i==src; the youngest (lowest i) match SHALL win.
REQ-017 A match SHALL give fwd=i+1; no match SHALL give fwd=0; fwd outputs SHALL be combinational.
REQ-018 dep_stall SHALL be 1 when either winning match has is_load=1 and i<LOAD_STAGE.
REQ-019 hazard_stall SHALL equal exe_stall | (id_valid & ~flush & dep_stall).
REQ-020 ex_bubble SHALL equal ~exe_stall & id_valid & (flush | dep_stall).
REQ-021 Edge with exe_stall=0: stage i+1 SHALL take stage i; stage 0 SHALL take the decode record if id_valid & ~flush & ~dep_stall, else an invalid record.
REQ-022 Edge with exe_stall=1: stage 0 SHALL hold, stage 1 SHALL take an invalid record, stages >=2 SHALL shift, and the decode record SHALL NOT enter.
REQ-023 Simultaneous flush and dep_stall: flush SHALL win (no stall, bubble); simultaneous flush and exe_stall: stage 0 SHALL hold.
REQ-024 The record leaving stage NSTAGE-1 SHALL be discarded.
REQ-025 Latency: a record SHALL be visible at stage 0 one edge after acceptance and reach stage NSTAGE-1 after NSTAGE edges, absent exe_stall.

Reset
REQ-026 resetn=0 SHALL asynchronously clear every scoreboard record to invalid.
REQ-027 Under reset, hazard_stall=0, ex_bubble=0, rs_fwd=rt_fwd=0 and stage_valid=0 SHALL hold (given exe_stall=0).
REQ-028 Reset mid-operation SHALL discard all in-flight records; the first post-reset decode SHALL see no matches.

Configuration
REQ-029 HAZARD_FWD_EN defined: forwarding SHALL follow REQ-016..018.
REQ-030 HAZARD_FWD_EN undefined: rs_fwd=rt_fwd=0 SHALL hold permanently, and dep_stall SHALL be 1 on any match in any stage (interlock until retire).

Structure
REQ-031 Shared package hazard_pkg SHALL hold the scoreboard record typedef, the FWD_REGFILE=0 constant and the EX/MEM/WB stage index constants.
REQ-032 One sub-module hazard_match SHALL do the per-source youngest-match priority encode and SHALL be instantiated twice (rs, rt).

Verification
REQ-033 Back-to-back ALU ops, r8 written then r8 read as rs -> rs_fwd=1, hazard_stall=0.
REQ-034 Load r9 followed immediately by use of r9 as rt (LOAD_STAGE=1) -> one cycle hazard_stall=1, ex_bubble=1, then rt_fwd=2, stall=0.
REQ-035 r10 written in stage 0 and stage 2, read as rs -> rs_fwd=1 (youngest wins); read of r0 -> fwd=0.
REQ-036 exe_stall high 4 cycles with ALU r11 in stage 0 -> stage_valid=3'b001 after 2 edges, stage 0 held, hazard_stall=1 throughout, ex_bubble=0.
REQ-037 Load-use stall cycle with flush=1 -> hazard_stall=0, ex_bubble=1, no record enters.
REQ-038 resetn pulsed low with stage_valid=3'b111 -> stage_valid=0 immediately; HAZARD_FWD_EN undefined build: REQ-033 stimulus -> 3 stall cycles, rs_fwd=0.
